// File: rtl/key_move_conditioner_pkg.sv
// ui_pkg: shared constants and move FSM state type for the KEY/SW input stage
package ui_pkg;
    localparam int CELL_W = 4;
    localparam logic [CELL_W-1:0] MAX_CELL = 4'd8;
    localparam int KEY_RESET = 0;
    localparam int KEY_MOVE = 1;
    typedef enum logic {IDLE, PENDING} move_state_t;
endpackage

// File: rtl/key_move_conditioner_if.sv
// key_move_conditioner_if: move offer handshake and game reset command toward the game
interface key_move_conditioner_if;
    logic                      move_valid;
    logic [ui_pkg::CELL_W-1:0] move_cell;
    logic                      move_ready;
    logic                      move_err;
    logic                      game_reset;
    modport master (output move_valid, move_cell, move_err, game_reset, input move_ready);
    modport slave (input move_valid, move_cell, move_err, game_reset, output move_ready);
endinterface

// File: rtl/key_move_conditioner_debouncer.sv
// key_debouncer: accepts a level change only after DEBOUNCE_CYCLES stable cycles, pulses on press
module key_debouncer #(
    parameter int DEBOUNCE_CYCLES = 15625,
    parameter int CNT_W = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic press
);
    logic [CNT_W-1:0] cnt_q;
    logic level_q, prev_q, press_q;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q   <= '0;
            level_q <= 1'b0;
            prev_q  <= 1'b0;
            press_q <= 1'b0;
        end else begin
            // any reversion to the accepted level restarts qualification
            if (raw == level_q) cnt_q <= '0;
            else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                level_q <= raw;
                cnt_q   <= '0;
            end else cnt_q <= cnt_q + CNT_W'(1);
            prev_q  <= level_q;
            press_q <= level_q & ~prev_q;
        end
    end
    assign level = level_q;
    assign press = press_q;
endmodule

// File: rtl/key_move_conditioner.sv
// key_move_conditioner: syncs/debounces KEY and SW, issues game reset and moves over valid/ready
module key_move_conditioner import ui_pkg::*; #(
    parameter int N_KEYS = 4,
    parameter int N_SW = 10,
    parameter int DEBOUNCE_CYCLES = 15625,
    parameter int CNT_W = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N_KEYS-1:0] key_n,
    input  logic [N_SW-1:0]   sw,
    output logic [N_KEYS-1:0] key_level,
    output logic [N_KEYS-1:0] key_press,
    output logic [N_SW-1:0]   sw_sync,
    key_move_conditioner_if.master mv
);
    logic [N_KEYS-1:0] key_s1_q, key_s2_q;
    logic [N_SW-1:0]   sw_s1_q, sw_s2_q;
    move_state_t       state_q;
    logic              valid_q, err_q, gr_q;
    logic [CELL_W-1:0] cell_q;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            key_s1_q <= '1;
            key_s2_q <= '1;
            sw_s1_q  <= '0;
            sw_s2_q  <= '0;
        end else begin
            key_s1_q <= key_n;
            key_s2_q <= key_s1_q;
            sw_s1_q  <= sw;
            sw_s2_q  <= sw_s1_q;
        end
    end
    for (genvar k = 0; k < N_KEYS; k++) begin : g_db
        key_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db (
            .clk(clk), .reset(reset), .raw(~key_s2_q[k]),
            .level(key_level[k]), .press(key_press[k])
        );
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            cell_q  <= '0;
            err_q   <= 1'b0;
            gr_q    <= 1'b0;
        end else begin
            gr_q  <= key_press[KEY_RESET];
            err_q <= 1'b0;
            // a reset press aborts any pending move and beats a coincident move press
            if (key_press[KEY_RESET]) begin
                state_q <= IDLE;
                valid_q <= 1'b0;
            end else if (state_q == IDLE) begin
                if (key_press[KEY_MOVE] && sw_s2_q[CELL_W-1:0] <= MAX_CELL) begin
                    cell_q  <= sw_s2_q[CELL_W-1:0];
                    valid_q <= 1'b1;
                    state_q <= PENDING;
                end else if (key_press[KEY_MOVE]) err_q <= 1'b1;
            end else if (mv.move_ready) begin
                valid_q <= 1'b0;
                state_q <= IDLE;
            end
        end
    end
    assign sw_sync       = sw_s2_q;
    assign mv.move_valid = valid_q;
    assign mv.move_cell  = cell_q;
    assign mv.move_err   = err_q;
    assign mv.game_reset = gr_q;
endmodule
